// File: rtl/icache_fill_sequencer.sv
// icache_fill_sequencer
// Collects even/odd bank line misses from fetch-1 and sends them one at a time
// to the single lower-level memory port. Round-robin picks between the banks.
// Each returned line goes back to the icache fill port as a one-cycle strobe.
// While misses are outstanding the sequencer holds fetch stall. On a resteer
// flush it discards queued work, and an in-flight request still completes on
// the memory port but its response is dropped.
//
// Handshake semantics (memory request channel): mem_req_valid rises together
// with a stable mem_req_addr and stays high, address unchanged, until the
// cycle in which mem_req_ready is sampled high; the transfer happens on that
// clock edge and valid falls in the following cycle. Valid is never withdrawn
// early, not even by flush. mem_rsp_valid is a single-cycle strobe that is only
// consumed while waiting for a response and is ignored in every other state.
module icache_fill_sequencer #(
  parameter int XLEN      = 32,
  parameter int CL_SIZE   = 128,
  parameter int CLC_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_even_valid,
  input  logic [CLC_WIDTH-1:0] miss_even_clc,
  input  logic                 miss_odd_valid,
  input  logic [CLC_WIDTH-1:0] miss_odd_clc,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [XLEN-1:0]      mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [CL_SIZE-1:0]   mem_rsp_data,
  input  logic                 mem_rsp_err,
  output logic                 fill_valid,
  output logic                 fill_odd,
  output logic [CLC_WIDTH-1:0] fill_clc,
  output logic [CL_SIZE-1:0]   fill_data,
  output logic                 fill_err,
  output logic                 stall,
  output logic [31:0]          perf_miss_cycles,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t                state;

  // Per-bank pending miss captured from the requester
  logic                  pend_even;
  logic                  pend_odd;
  logic [CLC_WIDTH-1:0]  pend_clc_even;
  logic [CLC_WIDTH-1:0]  pend_clc_odd;

  // Bank granted most recently; reset to odd so even wins the first tie
  logic                  last_grant_odd;

  // The transaction currently owned by the memory port
  logic                  req_odd;
  logic [CLC_WIDTH-1:0]  req_clc;

  // Set by a flush while a request is in flight; its response is thrown away
  logic                  drop;

  // Registered fill strobe before the same-cycle flush gate
  logic                  fill_q;

  logic [31:0]           perf_cnt;

  logic                  busy;
  logic                  inflight_even;
  logic                  inflight_odd;
  logic                  cap_even;
  logic                  cap_odd;
  logic                  grant_any;
  logic                  grant_odd;

  // Capture qualification, round-robin grant choice and fetch stall
  always_comb begin
    busy          = 1'b0;
    inflight_even = 1'b0;
    inflight_odd  = 1'b0;
    cap_even      = 1'b0;
    cap_odd       = 1'b0;
    grant_any     = 1'b0;
    grant_odd     = 1'b0;
    stall         = 1'b0;

    busy          = (state != S_IDLE);
    // A bank is in flight from its grant until the FSM is back in IDLE
    inflight_even = busy & ~req_odd;
    inflight_odd  = busy &  req_odd;

    // Flush wins over a miss presented in the same cycle
    cap_even = miss_even_valid & ~pend_even & ~inflight_even & ~flush;
    cap_odd  = miss_odd_valid  & ~pend_odd  & ~inflight_odd  & ~flush;

    // Grant looks only at registered pend flags, never at this cycle's capture
    grant_any = (pend_even | pend_odd) & ~flush;
    if (pend_even & pend_odd) begin
      grant_odd = ~last_grant_odd;
    end else begin
      grant_odd = pend_odd;
    end

    stall = pend_even | pend_odd | miss_even_valid | miss_odd_valid |
            (busy & ~drop);
  end

  // Main sequencer: miss capture, grant, memory request and fill registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      pend_even      <= 1'b0;
      pend_odd       <= 1'b0;
      pend_clc_even  <= '0;
      pend_clc_odd   <= '0;
      last_grant_odd <= 1'b1;
      req_odd        <= 1'b0;
      req_clc        <= '0;
      drop           <= 1'b0;
      mem_req_valid  <= 1'b0;
      fill_q         <= 1'b0;
      fill_odd       <= 1'b0;
      fill_clc       <= '0;
      fill_data      <= '0;
      fill_err       <= 1'b0;
    end else begin
      if (flush) begin
        pend_even <= 1'b0;
        pend_odd  <= 1'b0;
      end else begin
        if (cap_even) begin
          pend_even     <= 1'b1;
          pend_clc_even <= miss_even_clc;
        end
        if (cap_odd) begin
          pend_odd     <= 1'b1;
          pend_clc_odd <= miss_odd_clc;
        end
      end

      unique case (state)
        S_IDLE: begin
          if (grant_any) begin
            state          <= S_REQ;
            mem_req_valid  <= 1'b1;
            req_odd        <= grant_odd;
            last_grant_odd <= grant_odd;
            if (grant_odd) begin
              req_clc  <= pend_clc_odd;
              pend_odd <= 1'b0;
            end else begin
              req_clc   <= pend_clc_even;
              pend_even <= 1'b0;
            end
          end
        end

        S_REQ: begin
          if (flush) begin
            drop <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (drop | flush) begin
              // Response consumed but discarded; drop is cleared entering IDLE
              state <= S_IDLE;
              drop  <= 1'b0;
            end else begin
              state     <= S_FILL;
              fill_q    <= 1'b1;
              fill_odd  <= req_odd;
              fill_clc  <= req_clc;
              fill_data <= mem_rsp_data;
              fill_err  <= mem_rsp_err;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end

        S_FILL: begin
          fill_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating count of cycles in which fetch is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (stall && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  // A flush arriving during the fill cycle cancels that fill
  assign fill_valid       = fill_q & ~flush;
  assign mem_req_addr     = {req_clc, 4'b0000};
  assign perf_miss_cycles = perf_cnt;
  assign dbg_state        = state;

endmodule

// File: tb/tb_icache_fill_sequencer.sv
// Directed plus randomized bench for icache_fill_sequencer. A transaction-level
// model predicts the order of memory requests (round-robin over the banks) and
// the fills that must come back. The bench itself acts as both the requester and
// the memory.
module tb_icache_fill_sequencer;

  localparam int XLEN = 32;
  localparam int CLS  = 128;
  localparam int CLCW = 28;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            miss_even_valid;
  logic [CLCW-1:0] miss_even_clc;
  logic            miss_odd_valid;
  logic [CLCW-1:0] miss_odd_clc;
  logic            flush;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [CLS-1:0]  mem_rsp_data;
  logic            mem_rsp_err;
  logic            fill_valid;
  logic            fill_odd;
  logic [CLCW-1:0] fill_clc;
  logic [CLS-1:0]  fill_data;
  logic            fill_err;
  logic            stall;
  logic [31:0]     perf_miss_cycles;
  logic [1:0]      dbg_state;

  typedef struct packed {
    logic            odd;
    logic [CLCW-1:0] clc;
    logic [CLS-1:0]  data;
    logic            err;
  } fill_t;

  int          checks = 0;
  int          errors = 0;
  bit          m_last_odd;
  logic [31:0] exp_q[$];
  fill_t       exp_fill_q[$];
  fill_t       rsp_q[$];

  icache_fill_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .miss_even_valid  (miss_even_valid),
    .miss_even_clc    (miss_even_clc),
    .miss_odd_valid   (miss_odd_valid),
    .miss_odd_clc     (miss_odd_clc),
    .flush            (flush),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .mem_rsp_err      (mem_rsp_err),
    .fill_valid       (fill_valid),
    .fill_odd         (fill_odd),
    .fill_clc         (fill_clc),
    .fill_data        (fill_data),
    .fill_err         (fill_err),
    .stall            (stall),
    .perf_miss_cycles (perf_miss_cycles),
    .dbg_state        (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: one granted transaction -> one request address and one fill
  task automatic model_push(input bit odd, input logic [CLCW-1:0] clc, input int errm);
    fill_t f;
    f.odd  = odd;
    f.clc  = clc;
    f.data = {$urandom, $urandom, $urandom, $urandom};
    f.err  = (errm == 2) ? ($urandom_range(0, 3) == 0) : (errm == 1);
    exp_q.push_back({clc, 4'h0});
    exp_fill_q.push_back(f);
    rsp_q.push_back(f);
  endtask

  // Requester + memory driver for one miss group; checks requests, fills, timing
  task automatic run_misses(input bit ev, input bit od, input logic [CLCW-1:0] ce,
                            input logic [CLCW-1:0] co, input int rdly, input int sdly,
                            input int errm);
    bit          first_odd;
    bit          in_req;
    bit          wait_rsp;
    int          k;
    int          cnt;
    int          rcnt;
    int          rsp_k;
    int          req_k;
    int          fill_k;
    logic [31:0] cur;
    logic [31:0] base;
    logic [31:0] expp;
    fill_t       e;
    fill_t       r;

    @(negedge clk);
    base = perf_miss_cycles;
    if (ev && od) begin
      first_odd = ~m_last_odd;
      model_push(first_odd, first_odd ? co : ce, errm);
      model_push(~first_odd, first_odd ? ce : co, errm);
      m_last_odd = ~first_odd;
    end else if (ev) begin
      model_push(1'b0, ce, errm);
      m_last_odd = 1'b0;
    end else begin
      model_push(1'b1, co, errm);
      m_last_odd = 1'b1;
    end
    miss_even_valid = ev;
    miss_even_clc   = ce;
    miss_odd_valid  = od;
    miss_odd_clc    = co;
    k = 0; in_req = 0; wait_rsp = 0; rsp_k = -10; req_k = -1; fill_k = -1;
    cnt = 0; rcnt = 0; cur = '0;
    while ((exp_fill_q.size() != 0 || miss_even_valid || miss_odd_valid) && k < 400) begin
      @(negedge clk);
      k++;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (fill_valid) begin
        if (exp_fill_q.size() == 0) begin
          chk("unexpected_fill", 1, 0);
        end else begin
          e = exp_fill_q.pop_front();
          chk("fill", {fill_odd, fill_clc, fill_data, fill_err}, e);
          chk("fill_latency", k - rsp_k, 1);
          if (e.odd) miss_odd_valid = 1'b0;
          else miss_even_valid = 1'b0;
          fill_k = k;
        end
      end
      if (mem_req_valid) begin
        if (wait_rsp || exp_q.size() == 0) begin
          chk("dup_req", 1, 0);
        end else if (!in_req) begin
          in_req = 1;
          cnt    = rdly;
          cur    = exp_q[0];
          if (req_k < 0) req_k = k;
          chk("req_addr", mem_req_addr, cur);
        end else begin
          chk("req_addr_hold", mem_req_addr, cur);
        end
        if (in_req && cnt == 0) begin
          mem_req_ready = 1'b1;
          in_req        = 0;
          void'(exp_q.pop_front());
          wait_rsp      = 1;
          rcnt          = sdly;
        end else begin
          cnt--;
        end
      end else if (wait_rsp) begin
        if (rcnt == 0) begin
          r             = rsp_q.pop_front();
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = r.data;
          mem_rsp_err   = r.err;
          wait_rsp      = 0;
          rsp_k         = k;
        end else begin
          rcnt--;
        end
      end
    end
    chk("txn_within_budget", (k < 400), 1);
    chk("first_req_cycle", req_k, 2);
    if (ev ^ od) chk("single_fill_cycle", fill_k, 4 + rdly + sdly);
    @(negedge clk);
    chk("stall_released", stall, 0);
    chk("req_idle", mem_req_valid, 0);
    expp = base + 32'(fill_k + 1);
    chk("perf_stall_cycles", perf_miss_cycles, expp);
  endtask

  // Bring one bank's miss to the memory port; optionally accept it (-> WAIT)
  task automatic drive_to_req(input bit od, input logic [CLCW-1:0] c, input bit give_ready);
    int k;
    @(negedge clk);
    if (od) begin
      miss_odd_valid = 1'b1;
      miss_odd_clc   = c;
    end else begin
      miss_even_valid = 1'b1;
      miss_even_clc   = c;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_req_valid && k < 20);
    chk("req_seen", mem_req_valid, 1);
    chk("req_addr_d", mem_req_addr, {c, 4'h0});
    m_last_odd = od;
    if (give_ready) begin
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("valid_low_after_accept", mem_req_valid, 0);
    end
  endtask

  initial begin
    miss_even_valid = 0; miss_even_clc = '0;
    miss_odd_valid  = 0; miss_odd_clc  = '0;
    flush = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rsp_data = '0; mem_rsp_err = 0;
    m_last_odd = 1'b1;

    // Reset state
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_perf", perf_miss_cycles, 0);
    chk("rst_addr", mem_req_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Both banks after reset: even first, then odd; next pair flips order
    run_misses(1, 1, 28'h0000020, 28'h0000021, 0, 1, 0);
    run_misses(1, 1, 28'h0000030, 28'h0000031, 1, 0, 0);

    // Single even miss, ready same cycle, response a few cycles later
    run_misses(1, 0, 28'h0000010, 28'h0, 0, 2, 0);

    // Ready withheld for 5 cycles: request must hold steady
    run_misses(0, 1, 28'h0, 28'h0ABCDEF, 5, 1, 0);

    // Access fault propagates to fill_err
    run_misses(1, 0, 28'h1234567, 28'h0, 1, 1, 1);

    // Flush in WAIT with a same-cycle even miss
    drive_to_req(1, 28'h0000ABC, 1);
    chk("stall_in_wait", stall, 1);
    flush = 1'b1; miss_odd_valid = 1'b0;
    miss_even_valid = 1'b1; miss_even_clc = 28'h0000DEF;
    @(negedge clk);
    flush = 1'b0; miss_even_valid = 1'b0;
    #1 chk("stall_after_flush", stall, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'hDEADBEEF}}; mem_rsp_err = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("dropped_no_fill", fill_valid, 0);
      chk("dropped_no_req", mem_req_valid, 0);
      @(negedge clk);
    end
    run_misses(1, 0, 28'h0000DEF, 28'h0, 0, 0, 0);

    // Flush during the fill cycle suppresses the strobe
    drive_to_req(0, 28'h0000777, 1);
    mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'h0BADF00D}}; mem_rsp_err = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("fill_before_flush", fill_valid, 1);
    chk("fill_clc_before_flush", fill_clc, 28'h0000777);
    flush = 1'b1; miss_even_valid = 1'b0;
    #1 chk("fill_suppressed", fill_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("fill_after_flush", fill_valid, 0);
    chk("stall_after_fill_flush", stall, 0);

    // Randomized miss groups
    for (int i = 0; i < 25; i++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_misses(sel[0], sel[1], 28'($urandom), 28'($urandom),
                 $urandom_range(0, 4), $urandom_range(0, 4), 2);
    end

    // Saturation: park in REQ with stall high, preload counter near the top
    drive_to_req(1, 28'h0FEDCBA, 0);
    force dut.perf_cnt = 32'hFFFF_FFFD;
    #1 release dut.perf_cnt;
    @(negedge clk);
    chk("perf_inc", perf_miss_cycles, 32'hFFFF_FFFE);
    repeat (3) @(negedge clk);
    chk("perf_saturated", perf_miss_cycles, 32'hFFFF_FFFF);
    chk("req_still_held", mem_req_valid, 1);
    chk("req_addr_still_held", mem_req_addr, {28'h0FEDCBA, 4'h0});

    // Asynchronous reset mid-request
    #2 rst = 1'b0;
    #1;
    chk("arst_req_valid", mem_req_valid, 0);
    chk("arst_fill_valid", fill_valid, 0);
    chk("arst_perf", perf_miss_cycles, 0);
    chk("arst_stall_from_input", stall, 1);
    miss_odd_valid = 1'b0;
    #1 chk("arst_stall_no_input", stall, 0);
    @(negedge clk);
    rst = 1'b1;
    m_last_odd = 1'b1;

    // After reset even again wins the tie
    run_misses(1, 1, 28'h0000040, 28'h0000041, 0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
